// File: rtl/nor_logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit whose whole datapath is built from 2-input NOR gates.
// Stage 1 captures operands and op; stage 2 registers the result with zero and parity flags.
module nor_logic_unit_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity
);

    typedef enum logic [2:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpNotA = 3'b010,
        OpXor  = 3'b011,
        OpXnor = 3'b100,
        OpNand = 3'b101,
        OpNor  = 3'b110,
        OpBufA = 3'b111
    } op_e;

    localparam int unsigned Nodes = 2 * WIDTH - 1;

    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q, b_q;
    op_e              op_q;
    logic             out_valid_q, out_zero_q, out_parity_q;
    logic [WIDTH-1:0] out_y_q;
    logic             s2_free, s1_adv, in_fire;
    logic [WIDTH-1:0] res;
    wire              zero_c;

    wire [WIDTH-1:0] not_a, not_b, nor_ab, or_ab, and_ab, x_a, x_b, xnor_ab, xor_ab, nand_ab, buf_a;
    wire [Nodes-1:0] par_node, any_node;

    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !s1_valid_q || s2_free;
        in_fire  = in_valid && in_ready;
    end

    // Per-bit gate network; XOR is the classic five-NOR cell, XNOR taps its fourth gate.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nor u_not_a (not_a[i], a_q[i], a_q[i]);
        nor u_not_b (not_b[i], b_q[i], b_q[i]);
        nor u_nor   (nor_ab[i], a_q[i], b_q[i]);
        nor u_or    (or_ab[i], nor_ab[i], nor_ab[i]);
        nor u_and   (and_ab[i], not_a[i], not_b[i]);
        nor u_x_a   (x_a[i], a_q[i], nor_ab[i]);
        nor u_x_b   (x_b[i], b_q[i], nor_ab[i]);
        nor u_xnor  (xnor_ab[i], x_a[i], x_b[i]);
        nor u_xor   (xor_ab[i], xnor_ab[i], xnor_ab[i]);
        nor u_nand  (nand_ab[i], and_ab[i], and_ab[i]);
        nor u_buf   (buf_a[i], not_a[i], not_a[i]);
    end

    always_comb begin
        res = '0;
        unique case (op_q)
            OpAnd:  res = and_ab;
            OpOr:   res = or_ab;
            OpNotA: res = not_a;
            OpXor:  res = xor_ab;
            OpXnor: res = xnor_ab;
            OpNand: res = nand_ab;
            OpNor:  res = nor_ab;
            OpBufA: res = buf_a;
            default: res = '0;
        endcase
    end

    // Heap-ordered reduction trees: leaves at WIDTH-1.., node j combines 2j+1 and 2j+2.
    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
        assign par_node[WIDTH-1+i] = res[i];
        assign any_node[WIDTH-1+i] = res[i];
    end

    for (genvar j = 0; j < WIDTH - 1; j++) begin : g_tree
        wire p_n, p_a, p_b, p_xn, o_n;
        nor u_p_n  (p_n, par_node[2*j+1], par_node[2*j+2]);
        nor u_p_a  (p_a, par_node[2*j+1], p_n);
        nor u_p_b  (p_b, par_node[2*j+2], p_n);
        nor u_p_xn (p_xn, p_a, p_b);
        nor u_p_x  (par_node[j], p_xn, p_xn);
        nor u_o_n  (o_n, any_node[2*j+1], any_node[2*j+2]);
        nor u_o    (any_node[j], o_n, o_n);
    end

    nor u_zero (zero_c, any_node[0], any_node[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OpAnd;
            out_valid_q  <= 1'b0;
            out_y_q      <= '0;
            out_zero_q   <= 1'b0;
            out_parity_q <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                a_q        <= in_a;
                b_q        <= in_b;
                op_q       <= op_e'(in_op);
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_adv) begin
                out_valid_q  <= 1'b1;
                out_y_q      <= res;
                out_zero_q   <= zero_c;
                out_parity_q <= par_node[0];
            end else if (s2_free) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_y      = out_y_q;
    assign out_zero   = out_zero_q;
    assign out_parity = out_parity_q;

endmodule

// File: tb/tb_nor_logic_unit_pipe.sv
// Self-checking bench for nor_logic_unit_pipe: three widths share stimulus, one is observed at a
// time and scored against a queue-based reference model of the logic operations.
module tb_nor_logic_unit_pipe;

    typedef struct packed {
        logic [63:0] y;
        logic        z;
        logic        p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [63:0] in_a, in_b;
    logic [2:0]  in_op;
    int          sel;

    logic        ir8, ov8, z8, p8, ir1, ov1, z1, p1, ir32, ov32, z32, p32;
    logic [7:0]  y8;
    logic [0:0]  y1;
    logic [31:0] y32;

    logic        cur_ir, cur_ov, cur_z, cur_p;
    logic [63:0] cur_y;
    int          cur_w;

    int          total = 0;
    int          bad = 0;
    exp_t        exp_q[$];
    logic [63:0] got_q[$];
    logic        hold_v = 1'b0;
    logic [63:0] hold_y;
    logic [7:0]  gold [8] = '{8'h24, 8'hBD, 8'h5A, 8'h99, 8'h66, 8'hDB, 8'h42, 8'hA5};

    always #5 clk = ~clk;

    nor_logic_unit_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .in_a(in_a[7:0]),
        .in_b(in_b[7:0]), .in_op(in_op), .out_valid(ov8), .out_ready(out_ready), .out_y(y8),
        .out_zero(z8), .out_parity(p8)
    );
    nor_logic_unit_pipe #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_a(in_a[0:0]),
        .in_b(in_b[0:0]), .in_op(in_op), .out_valid(ov1), .out_ready(out_ready), .out_y(y1),
        .out_zero(z1), .out_parity(p1)
    );
    nor_logic_unit_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .in_a(in_a[31:0]),
        .in_b(in_b[31:0]), .in_op(in_op), .out_valid(ov32), .out_ready(out_ready), .out_y(y32),
        .out_zero(z32), .out_parity(p32)
    );

    always_comb begin
        cur_ir = ir8; cur_ov = ov8; cur_z = z8; cur_p = p8; cur_y = {56'd0, y8}; cur_w = 8;
        if (sel == 1) begin
            cur_ir = ir1; cur_ov = ov1; cur_z = z1; cur_p = p1; cur_y = {63'd0, y1}; cur_w = 1;
        end else if (sel == 2) begin
            cur_ir = ir32; cur_ov = ov32; cur_z = z32; cur_p = p32; cur_y = {32'd0, y32};
            cur_w = 32;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input int w);
        logic [63:0] r, m;
        exp_t        e;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~a;
            3'd3: r = a ^ b;
            3'd4: r = ~(a ^ b);
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a;
        endcase
        e.y = r & m;
        e.z = (e.y == 64'd0);
        e.p = ^e.y;
        return e;
    endfunction

    // Scoreboard: everything is decided by levels that are stable across the coming rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v && cur_ov) check("hold_y", cur_y, hold_y);
            if (cur_ov && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stale_beat", cur_ov, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_y", cur_y, e.y);
                    check("sb_zero", cur_z, e.z);
                    check("sb_parity", cur_p, e.p);
                    got_q.push_back(cur_y);
                end
            end
            hold_v = cur_ov && !out_ready;
            hold_y = cur_y;
            if (in_valid && cur_ir) exp_q.push_back(model(in_op, in_a, in_b, cur_w));
        end
    end

    task automatic do_reset(input int n, input int s);
        @(posedge clk); #1;
        rst = 1'b1; sel = s; in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic one_beat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] ey, input logic ez, input logic ep,
                            input string tag);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
        @(negedge clk); check({tag, "_accept"}, cur_ir, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); check({tag, "_early"}, cur_ov, 0);
        @(negedge clk);
        check({tag, "_valid"}, cur_ov, 1);
        check({tag, "_y"}, cur_y, ey);
        check({tag, "_zero"}, cur_z, ez);
        check({tag, "_parity"}, cur_p, ep);
    endtask

    // Random valid/ready toggling; fixed mode cycles ops 0..7 on constant operands.
    task automatic stream(input int n, input bit fixed, input logic [63:0] fa, input logic [63:0] fb);
        int idx = 0;
        int cyc = 0;
        got_q.delete();
        while ((idx < n || exp_q.size() != 0) && cyc < 4000) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            if (idx < n && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                if (fixed) begin
                    in_op = 3'(idx % 8); in_a = fa; in_b = fb;
                end else begin
                    in_op = 3'($urandom_range(0, 7));
                    in_a  = {$urandom, $urandom};
                    in_b  = {$urandom, $urandom};
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk); #1;
            if (in_valid && cur_ir) idx++;
            cyc++;
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        check("stream_sent", 64'(idx), 64'(n));
        check("stream_drained", 64'(exp_q.size()), 0);
    endtask

    initial begin
        int idx;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1; sel = 0;

        // Reset for two edges with a beat offered that must be discarded.
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; in_a = 64'hFF; in_op = 3'd7;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", cur_ir, 1);
        check("rst_out_valid", cur_ov, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_q_valid", cur_ov, 0);
        check("rst_q_y", cur_y, 0);
        check("rst_q_zero", cur_z, 0);
        check("rst_q_parity", cur_p, 0);
        check("rst_q_in_ready", cur_ir, 1);
        @(negedge clk);
        check("rst_discard", cur_ov, 0);

        // All ops back to back, results two cycles later, one per cycle.
        got_q.delete();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_valid = (k < 8); in_op = 3'(k % 8); in_a = 64'hA5; in_b = 64'h3C;
            @(negedge clk);
            if (k >= 2) begin
                check("ops_valid", cur_ov, 1);
                check("ops_y", cur_y, {56'd0, gold[k-2]});
                check("ops_parity", cur_p, 0);
            end else begin
                check("ops_latency", cur_ov, 0);
            end
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);

        one_beat(3'd0, 64'hFF, 64'h00, 64'h00, 1'b1, 1'b0, "flag_and");
        one_beat(3'd7, 64'h01, 64'hAA, 64'h01, 1'b0, 1'b1, "flag_buf");

        // Backpressure: two beats fit, the rest wait until the consumer returns.
        @(posedge clk); #1;
        got_q.delete(); out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            in_valid = (idx < 4); in_op = 3'd3; in_a = 64'h0F; in_b = 64'(idx);
            @(negedge clk); #1;
            if (c >= 2) begin
                check("bp_hold_y", cur_y, 64'h0F);
                check("bp_in_ready", cur_ir, 0);
            end
            if (in_valid && cur_ir) idx++;
        end
        check("bp_accepted", 64'(idx), 2);
        for (int c = 0; c < 20 && (idx < 4 || exp_q.size() != 0); c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1; in_valid = (idx < 4); in_b = 64'(idx);
            @(negedge clk); #1;
            if (in_valid && cur_ir) idx++;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        check("bp_count", 64'(got_q.size()), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("bp_order", got_q[i], 64'h0F - 64'(i));

        // Reset with two beats in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_op = 3'd1; in_a = 64'(c + 1); in_b = 64'h0;
        end
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", cur_ov, 0);
        one_beat(3'd1, 64'h10, 64'h01, 64'h11, 1'b0, 1'b0, "mid_rst_or");

        // Random traffic at WIDTH=8, then the width sweep.
        stream(150, 1'b0, '0, '0);

        do_reset(2, 1);
        stream(8, 1'b1, 64'hA5, 64'h3C);
        check("w1_count", 64'(got_q.size()), 8);
        stream(150, 1'b0, '0, '0);

        do_reset(2, 2);
        stream(8, 1'b1, 64'hDEADBEEF, 64'h0000FFFF);
        check("w32_count", 64'(got_q.size()), 8);
        if (got_q.size() >= 4) begin
            check("w32_and", got_q[0], 64'h0000BEEF);
            check("w32_xor", got_q[3], 64'hDEAD4110);
        end
        stream(200, 1'b0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nor_logic_unit_pipe.md
Name: nor_logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit. Every gate function is built only from two-input NOR primitives (nor_gate), replicated per bit with a generate loop over WIDTH.
- Successor to the single-bit combinational NOR gate set. Adds:
  - vector width;
  - runtime operation select;
  - two-stage registered pipeline with valid/ready flow control;
  - zero and parity status flags.
- Sits between an operand source and a result consumer. Either side may stall.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..64).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  unit can accept the offered beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B (ignored for NOT and BUF).
- in_op  input  3  operation select, sampled with the beat.
- out_valid  output  1  result beat available.
- out_ready  input  1  consumer accepts the result this cycle.
- out_y  output  WIDTH  result.
- out_zero  output  1  1 when out_y == 0.
- out_parity  output  1  XOR-reduction of out_y (odd parity = 1).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Op encoding: 000 AND, 001 OR, 010 NOT A, 011 XOR, 100 XNOR, 101 NAND, 110 NOR, 111 BUF A.
- NOR-only realisation, per bit:
  - NOT x = NOR(x,x)
  - OR = NOT(NOR)
  - AND = NOR(NOT a, NOT b)
  - XOR: 5-NOR form
  - XNOR = NOT XOR
  - NAND = NOT AND
  - BUF = NOT(NOT a)
  - parity: XOR tree from the same XOR cell
  - zero: NOR-tree reduction
- No behavioural operators (&, |, ^) in the datapath. Op mux is permitted in RTL.
- Stage 1 (capture):
  - Registers a, b, op and s1_valid on transfer (in_valid && in_ready).
- Stage 2 (compute/hold):
  - Computes the function from stage-1 registers.
  - Registers out_y, out_zero, out_parity and out_valid when stage 1 advances.
- Advance rules:
  - s2_free = !out_valid || out_ready
  - s1 advances into s2 when s1_valid && s2_free
  - in_ready = !s1_valid || s2_free (combinational, no dependence on in_valid)
- Latency and throughput:
  - Input transfer at cycle N gives out_valid at N+2 when there is no backpressure.
  - Throughput is 1 beat per cycle.
- Backpressure:
  - While out_valid && !out_ready: out_y, out_zero and out_parity hold stable.
  - Stage 1 holds its beat.
  - in_ready drops once stage 1 is occupied.
  - Maximum 2 beats in flight; no beat is dropped or duplicated.
- Simultaneous events:
  - Output consume and input accept in the same cycle are both legal.
  - Stage 1 refills in the same edge in which it drains.
- Flags always correspond to the registered out_y of the same beat.
- Reset:
  - rst=1 at a clock edge clears s1_valid, out_valid, out_y, out_zero and out_parity to 0, and the stage-1 data registers to 0.
  - While rst=1, in_ready is 1 after the edge. Any beat presented during reset is discarded.
  - Reset mid-stream discards all in-flight beats. First valid output appears 2 cycles after the first post-reset transfer.
- Ordering: strict FIFO order input to output.
- Illegal ops: none, all 8 encodings are defined.

Test Plan:
- Reset and quiescent outputs: assert rst 2 cycles -> out_valid=0, out_y=0x00, out_zero=0, out_parity=0, in_ready=1 after release.
- All ops, no backpressure: WIDTH=8, a=0xA5, b=0x3C, ops 0..7 back-to-back with out_ready=1 -> outputs at +2 cycles, in order:
  - 0x24, 0xBD, 0x5A, 0x99, 0x66, 0xDB, 0x42, 0xA5
  - parity 0,0,0,0,0,0,0,0
  - one result per cycle
- Zero/parity flags: a=0xFF, b=0x00, AND -> out_y=0x00, zero=1, parity=0; then a=0x01, BUF -> out_y=0x01, zero=0, parity=1.
- Backpressure: stream 4 beats (XOR of a=0x0F with b=0x00,0x01,0x02,0x03), hold out_ready=0 for 5 cycles ->
  - out_y stays 0x0F
  - in_ready=0 after 2 beats accepted
  - on release, results 0x0F, 0x0E, 0x0D, 0x0C appear in order with no loss.
- Reset mid-stream: 2 beats in flight, assert rst 1 cycle -> out_valid=0 next cycle, no stale beat emitted; a new beat (OR 0x10,0x01) gives out_y=0x11 two cycles after its transfer.
- Width sweep: rerun the all-ops scenario with WIDTH=1 and WIDTH=32 (a=0xDEADBEEF, b=0x0000FFFF) -> XOR=0xDEAD4110, AND=0x0000BEEF, checked against a golden model with random in_valid/out_ready toggling.
